// File: rtl/multi_channel_pattern_sequencer_pkg.sv
// seq_pkg: engine FSM states, ROM word field positions and the end-of-song marker
// shared by the multi-channel pattern sequencer files.
package seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ORD_ADDR,
        S_ORD_DATA,
        S_PAT_ADDR,
        S_PAT_DATA,
        S_OUT
    } state_t;
    localparam int ORD_OFF_LSB = 0;
    localparam int ORD_LEN_LSB = 8;
    localparam int NOTE_PITCH_LSB = 0;
    localparam int NOTE_LEN_LSB = 6;
    localparam int NOTE_INSTR_LSB = 11;
    localparam logic [7:0] END_MARKER_LEN = 8'd0;
endpackage

// File: rtl/multi_channel_pattern_sequencer_if.sv
// multi_channel_pattern_sequencer_if: note strobe/note output bundle plus the shared ROM port;
// master is the sequencer, slave is the tempo/voice/ROM side.
interface multi_channel_pattern_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 10
);
    logic [NUM_CH-1:0]   i_note_stb;
    logic [NUM_CH-1:0]   o_note_valid;
    logic [6*NUM_CH-1:0] o_note_pitch;
    logic [5*NUM_CH-1:0] o_note_len;
    logic [4*NUM_CH-1:0] o_note_instrument;
    logic [NUM_CH-1:0]   o_overrun;
    logic [NUM_CH-1:0]   o_halted;
    logic [ADDR_W-1:0]   o_rom_addr;
    logic [15:0]         i_rom_data;
    modport master (
        input  i_note_stb, i_rom_data,
        output o_note_valid, o_note_pitch, o_note_len, o_note_instrument, o_overrun, o_halted, o_rom_addr
    );
    modport slave (
        output i_note_stb, i_rom_data,
        input  o_note_valid, o_note_pitch, o_note_len, o_note_instrument, o_overrun, o_halted, o_rom_addr
    );
endinterface

// File: rtl/multi_channel_pattern_sequencer_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; the pointer names the highest-priority requester
// and moves past the winner whenever i_adv accepts a grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    input  logic         i_adv,
    output logic [N-1:0] o_grant
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next;
    logic [PW-1:0] w_idx;
    // scan from the farthest offset down so the nearest requester after the pointer wins
    always_comb begin
        o_grant = '0;
        w_next = r_ptr;
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = PW'((int'(r_ptr) + i) % N);
            if (i_req[w_idx]) begin
                o_grant = '0;
                o_grant[w_idx] = 1'b1;
                w_next = PW'((int'(w_idx) + 1) % N);
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) r_ptr <= '0;
        else if (i_adv && |i_req) r_ptr <= w_next;
    end
endmodule

// File: rtl/multi_channel_pattern_sequencer.sv
// multi_channel_pattern_sequencer: serves NUM_CH note strobes from one shared synchronous ROM,
// walking per-channel order tables and patterns with a song loop point and empty-song halt.
module multi_channel_pattern_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int ADDR_W       = 10,
    parameter int ORDER_LEN    = 16,
    parameter int ORDER_BASE   = 0,
    parameter int PATTERN_BASE = 256,
    parameter int LOOP_IDX     = 0
) (
    input logic i_clk,
    input logic i_rst,
    multi_channel_pattern_sequencer_if.master bus
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int OW = ORDER_LEN > 1 ? $clog2(ORDER_LEN) : 1;
    state_t              r_state;
    logic [CW-1:0]       r_grant;
    logic                r_looped;
    logic [NUM_CH-1:0]   r_pending, r_in_pattern, r_halted, r_valid, r_overrun;
    logic [OW-1:0]       r_order_idx [NUM_CH];
    logic [ADDR_W-1:0]   r_pat_addr [NUM_CH];
    logic [7:0]          r_pat_len [NUM_CH];
    logic [7:0]          r_pat_count [NUM_CH];
    logic [6*NUM_CH-1:0] r_pitch;
    logic [5*NUM_CH-1:0] r_len;
    logic [4*NUM_CH-1:0] r_instr;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [NUM_CH-1:0]   w_grant_oh, w_stb, w_clr;
    logic [CW-1:0]       w_gidx;
    logic [7:0]          w_ord_len;
    logic                w_end;
    logic [ADDR_W-1:0]   w_pat_start;
    function automatic logic [ADDR_W-1:0] ord_addr(input logic [CW-1:0] ch, input logic [OW-1:0] idx);
        return ADDR_W'(ORDER_BASE + int'(ch) * ORDER_LEN + int'(idx));
    endfunction
    rr_arbiter #(.N(NUM_CH)) u_arb (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_req  (r_pending),
        .i_adv  (r_state == S_IDLE),
        .o_grant(w_grant_oh)
    );
    always_comb begin
        w_gidx = '0;
        for (int c = 0; c < NUM_CH; c++) w_gidx = w_grant_oh[c] ? CW'(c) : w_gidx;
    end
    assign w_stb       = bus.i_note_stb & ~r_halted;
    assign w_ord_len   = bus.i_rom_data[ORD_LEN_LSB +: 8];
    assign w_end       = w_ord_len == END_MARKER_LEN;
    assign w_pat_start = ADDR_W'(PATTERN_BASE) + ADDR_W'(bus.i_rom_data[ORD_OFF_LSB +: 8]);
    // pending is released on the note pulse or when a second end marker halts the channel
    assign w_clr = (r_state == S_OUT || (r_state == S_ORD_DATA && w_end && r_looped))
                 ? NUM_CH'(1) << r_grant : '0;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_looped     <= 1'b0;
            r_pending    <= '0;
            r_in_pattern <= '0;
            r_halted     <= '0;
            r_valid      <= '0;
            r_overrun    <= '0;
            r_pitch      <= '0;
            r_len        <= '0;
            r_instr      <= '0;
            r_rom_addr   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_order_idx[c] <= '0;
                r_pat_addr[c]  <= '0;
                r_pat_len[c]   <= '0;
                r_pat_count[c] <= '0;
            end
        end else begin
            r_pending  <= (r_pending & ~w_clr) | w_stb;
            r_overrun  <= w_stb & r_pending & ~w_clr;
            r_valid    <= '0;
            r_rom_addr <= '0;
            case (r_state)
                S_IDLE: if (|r_pending) begin
                    r_grant    <= w_gidx;
                    r_looped   <= 1'b0;
                    r_state    <= r_in_pattern[w_gidx] ? S_PAT_ADDR : S_ORD_ADDR;
                    r_rom_addr <= r_in_pattern[w_gidx] ? r_pat_addr[w_gidx] : ord_addr(w_gidx, r_order_idx[w_gidx]);
                end
                S_ORD_ADDR: r_state <= S_ORD_DATA;
                S_ORD_DATA: if (!w_end) begin
                    r_pat_addr[r_grant]  <= w_pat_start;
                    r_pat_len[r_grant]   <= w_ord_len;
                    r_pat_count[r_grant] <= 8'd1;
                    r_rom_addr           <= w_pat_start;
                    r_state              <= S_PAT_ADDR;
                end else if (!r_looped) begin
                    r_looped             <= 1'b1;
                    r_order_idx[r_grant] <= OW'(LOOP_IDX);
                    r_rom_addr           <= ord_addr(r_grant, OW'(LOOP_IDX));
                    r_state              <= S_ORD_ADDR;
                end else begin
                    r_halted[r_grant] <= 1'b1;
                    r_state           <= S_IDLE;
                end
                S_PAT_ADDR: r_state <= S_PAT_DATA;
                S_PAT_DATA: begin
                    r_pitch[6*r_grant +: 6] <= bus.i_rom_data[NOTE_PITCH_LSB +: 6];
                    r_len[5*r_grant +: 5]   <= bus.i_rom_data[NOTE_LEN_LSB +: 5];
                    r_instr[4*r_grant +: 4] <= bus.i_rom_data[NOTE_INSTR_LSB +: 4];
                    r_valid[r_grant]        <= 1'b1;
                    r_state                 <= S_OUT;
                end
                S_OUT: begin
                    r_in_pattern[r_grant] <= r_pat_count[r_grant] < r_pat_len[r_grant];
                    if (r_pat_count[r_grant] < r_pat_len[r_grant]) begin
                        r_pat_addr[r_grant]  <= r_pat_addr[r_grant] + ADDR_W'(1);
                        r_pat_count[r_grant] <= r_pat_count[r_grant] + 8'd1;
                    end else r_order_idx[r_grant] <= r_order_idx[r_grant] + OW'(1);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign bus.o_note_valid      = r_valid;
    assign bus.o_note_pitch      = r_pitch;
    assign bus.o_note_len        = r_len;
    assign bus.o_note_instrument = r_instr;
    assign bus.o_overrun         = r_overrun;
    assign bus.o_halted          = r_halted;
    assign bus.o_rom_addr        = r_rom_addr;
endmodule

// File: tb/tb_multi_channel_pattern_sequencer.sv
// tb_multi_channel_pattern_sequencer: table-driven strobes with a note scoreboard (channel, fields,
// arrival cycle) plus hand sequences for overrun, halt, ROM addressing and mid-fetch reset.
module tb_multi_channel_pattern_sequencer;
    typedef struct { int ch; int pitch; int len; int instr; int due; } note_t;
    typedef struct { bit rst; logic [3:0] stb; int ch; int lat; int pitch; int len; int instr; int hold; } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0, checks = 0, failures = 0, t_last = 0;
    logic [15:0] rom [1024];
    note_t sb[$];
    vec_t tbl[8];
    multi_channel_pattern_sequencer_if #(.NUM_CH(4), .ADDR_W(10)) bus();
    multi_channel_pattern_sequencer #(
        .NUM_CH(4), .ADDR_W(10), .ORDER_LEN(16), .ORDER_BASE(0), .PATTERN_BASE(256), .LOOP_IDX(1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.i_rom_data <= rom[bus.o_rom_addr];
    task automatic chk(input string n, input longint a, input longint e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", n, a, e, cyc);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic strobe(input logic [3:0] m);
        bus.i_note_stb = m;
        @(negedge clk);
        bus.i_note_stb = '0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask
    task automatic expect_note(input int ch, input int p, input int l, input int i, input int due);
        sb.push_back('{ch, p, l, i, due});
    endtask
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) if (bus.o_note_valid[c]) begin
            if (sb.size() == 0) chk("unexpected_note", longint'(bus.o_note_valid), 0);
            else begin
                note_t e;
                e = sb.pop_front();
                chk("note{ch,pitch,len,instr,cycle}",
                    {8'(c), 8'(bus.o_note_pitch[6*c +: 6]), 8'(bus.o_note_len[5*c +: 5]),
                     8'(bus.o_note_instrument[4*c +: 4]), 32'(cyc)},
                    {8'(e.ch), 8'(e.pitch), 8'(e.len), 8'(e.instr), 32'(e.due)});
            end
        end
        if (sb.size() != 0 && sb[0].due < cyc) begin
            chk("missing_note_due_cycle", longint'(cyc), longint'(sb[0].due));
            void'(sb.pop_front());
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
    initial begin
        for (int a = 0; a < 1024; a++) rom[a] = '0;
        rom[0]   = 16'h0203;
        rom[1]   = 16'h0110;
        rom[2]   = 16'h0120;
        rom[16]  = 16'h0140;
        rom[32]  = 16'h0150;
        rom[259] = 16'h0A85;
        rom[260] = 16'h1041;
        rom[272] = 16'hFFFF;
        rom[288] = 16'h3A5C;
        rom[320] = 16'h1234;
        rom[336] = 16'h4321;
        tbl[0] = '{1'b0, 4'b0001, 0,  6,  5, 10,  1,  8};
        tbl[1] = '{1'b0, 4'b0001, 0,  4,  1,  1,  2,  6};
        tbl[2] = '{1'b0, 4'b0001, 0,  6, 63, 31, 15,  8};
        tbl[3] = '{1'b0, 4'b0001, 0,  6, 28,  9,  7,  8};
        tbl[4] = '{1'b0, 4'b0001, 0,  8, 63, 31, 15, 10};
        tbl[5] = '{1'b0, 4'b0001, 0,  6, 28,  9,  7,  8};
        tbl[6] = '{1'b1, 4'b0110, 1,  6, 52,  8,  2,  0};
        tbl[7] = '{1'b0, 4'b0000, 2, 12, 33, 12,  8, 14};
        bus.i_note_stb = '0;
        tick(3);
        chk("reset_valid", longint'(bus.o_note_valid), 0);
        chk("reset_pitch", longint'(bus.o_note_pitch), 0);
        chk("reset_len", longint'(bus.o_note_len), 0);
        chk("reset_instr", longint'(bus.o_note_instrument), 0);
        chk("reset_overrun", longint'(bus.o_overrun), 0);
        chk("reset_halted", longint'(bus.o_halted), 0);
        chk("reset_rom_addr", longint'(bus.o_rom_addr), 0);
        rst = 1'b0;
        tick(1);
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            if (tbl[i].stb != 0) t_last = cyc;
            expect_note(tbl[i].ch, tbl[i].pitch, tbl[i].len, tbl[i].instr, t_last + tbl[i].lat);
            if (tbl[i].stb != 0) strobe(tbl[i].stb);
            tick(tbl[i].hold);
        end
        do_reset();
        t_last = cyc;
        expect_note(2, 33, 12, 8, t_last + 6);
        strobe(4'b0100);
        tick(1);
        chk("rom_addr_order_ch2", longint'(bus.o_rom_addr), 32);
        tick(1);
        chk("rom_addr_between", longint'(bus.o_rom_addr), 0);
        tick(1);
        chk("rom_addr_pattern_ch2", longint'(bus.o_rom_addr), 336);
        tick(4);
        do_reset();
        t_last = cyc;
        expect_note(0, 5, 10, 1, t_last + 6);
        strobe(4'b0001);
        chk("overrun_first_strobe", longint'(bus.o_overrun), 0);
        tick(1);
        strobe(4'b0001);
        chk("overrun_pulse", longint'(bus.o_overrun), 4'b0001);
        tick(1);
        chk("overrun_one_cycle", longint'(bus.o_overrun), 0);
        tick(6);
        t_last = cyc;
        strobe(4'b1000);
        tick(4);
        chk("halted_before", longint'(bus.o_halted), 0);
        tick(1);
        chk("halted_set", longint'(bus.o_halted), 4'b1000);
        strobe(4'b1000);
        chk("halted_strobe_no_overrun", longint'(bus.o_overrun), 0);
        tick(1);
        chk("halted_strobe_no_overrun_late", longint'(bus.o_overrun), 0);
        tick(8);
        chk("halted_sticky", longint'(bus.o_halted), 4'b1000);
        strobe(4'b0001);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midreset_valid", longint'(bus.o_note_valid), 0);
        chk("midreset_pitch", longint'(bus.o_note_pitch), 0);
        chk("midreset_len", longint'(bus.o_note_len), 0);
        chk("midreset_instr", longint'(bus.o_note_instrument), 0);
        chk("midreset_halted", longint'(bus.o_halted), 0);
        chk("midreset_rom_addr", longint'(bus.o_rom_addr), 0);
        chk("midreset_overrun", longint'(bus.o_overrun), 0);
        tick(8);
        t_last = cyc;
        expect_note(0, 5, 10, 1, t_last + 6);
        strobe(4'b0001);
        tick(8);
        chk("scoreboard_empty", longint'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
